riscv_mem_arbiter: RTL and testbench
====================================

Name: riscv_mem_arbiter

Overview:
Shares one block-wide backing memory (the DRAM model) between the I-cache refill FSM and the D-cache refill/writeback FSM. This lets a single unified memory replace the split instruction/data RAM models. Sits between riscv_core memory ports and the memory model. Uses 2-way round-robin arbitration and holds each grant until the transaction completes.

Parameters:
DATA_WIDTH  128  cache block width in bits
S_ADDR      10   block address width (ADDR - BYTE_OFF)
TIMEOUT_CYC 1024 watchdog limit in cycles (used only with the optional feature)

Ports:
i_riscv_arb_clk        in   1           clock
i_riscv_arb_rst        in   1           asynchronous reset, active-high
i_riscv_arb_d_rden     in   1           D-side block read request (level, held until ready)
i_riscv_arb_d_wren     in   1           D-side block write request (level, held until ready)
i_riscv_arb_d_addr     in   S_ADDR      D-side block address
i_riscv_arb_d_wdata    in   DATA_WIDTH  D-side writeback data
o_riscv_arb_d_rdata    out  DATA_WIDTH  D-side read data
o_riscv_arb_d_ready    out  1           D-side completion, 1-cycle pulse
i_riscv_arb_i_rden     in   1           I-side block read request (level)
i_riscv_arb_i_addr     in   S_ADDR      I-side block address
o_riscv_arb_i_rdata    out  DATA_WIDTH  I-side read data
o_riscv_arb_i_ready    out  1           I-side completion, 1-cycle pulse
o_riscv_arb_mem_rden   out  1           memory read strobe
o_riscv_arb_mem_wren   out  1           memory write strobe
o_riscv_arb_mem_addr   out  S_ADDR      memory address
o_riscv_arb_mem_wdata  out  DATA_WIDTH  memory write data
i_riscv_arb_mem_rdata  in   DATA_WIDTH  memory read data
i_riscv_arb_mem_ready  in   1           memory completion

Behaviour:
- Reset: FSM=IDLE; rr_ptr=D (D wins the first tie); all strobes, readies and ready pulses 0; addr, wdata and rdata outputs 0.
- FSM states: IDLE, BUSY, RELEASE.
- IDLE -> BUSY when any request is present, on the next edge (1-cycle grant latency).
  - Grant register and op are latched: op is write if D has wren, otherwise read.
  - Address and wdata are latched from the granted requester.
- BUSY:
  - Drive the mem strobe, addr and wdata from the latched registers.
  - Hold them until i_riscv_arb_mem_ready=1.
  - In the mem_ready cycle, the granted side's ready = 1 combinationally. Its rdata = i_riscv_arb_mem_rdata, passed through that same cycle.
  - The ungranted side's ready and rdata stay 0.
  - Next state is RELEASE.
- RELEASE: strobes 0 for exactly 1 cycle so the requester can drop its request. Then IDLE.
- Round-robin rule:
  - When both sides request in IDLE, grant the side indicated by rr_ptr.
  - rr_ptr flips to the other side on every grant.
  - A lone requester is granted regardless of rr_ptr.
- D-side rden and wren both high: wren wins. Write only, no read.
- Requester inputs are ignored while in BUSY or RELEASE. Latched values are the ones used.
- Minimum turnaround per transaction: 1 (grant) + memory latency + 1 (release).
- Starvation bound: a continuously asserted request is granted within 1 transaction of the other side.
- Reset asserted mid-transaction: immediate return to IDLE. Strobes drop asynchronously; no ready is issued.

Optional Feature:
RISCV_ARB_TIMEOUT_EN
- Defined:
  - A counter runs in BUSY and clears on entry to BUSY.
  - If mem_ready is not seen within TIMEOUT_CYC cycles, the arbiter pulses the granted side's ready with rdata=0 and goes to RELEASE.
  - It also sets a sticky output o_riscv_arb_timeout (1 bit), cleared only by reset.
- Undefined: no counter and no timeout port; BUSY waits indefinitely.

Decomposition:
- Package riscv_arb_pkg holds:
  - state localparams IDLE=2'b00, BUSY=2'b01, RELEASE=2'b10;
  - requester IDs REQ_D=1'b0, REQ_I=1'b1;
  - op encoding OP_RD=1'b0, OP_WR=1'b1.
- Sub-module riscv_rr_arb2: 2-input round-robin grant logic plus the rr_ptr flop. Inputs are req[1:0] and an advance strobe; output is a one-hot grant.

Test Plan:
- D read alone, addr=10'h055, memory latency 3 cycles, mem_rdata=128'hA5..A5:
  - mem_rden rises 1 cycle after the request;
  - d_ready pulses once with d_rdata=A5..A5;
  - i_ready stays 0.
- D and I both request at the same edge after reset:
  - D granted first, then I, then D again if both are still asserted (alternation);
  - mem_addr follows the grant.
- D wren with wdata=128'h0123..CDEF, addr=10'h3FF:
  - mem_wren=1, mem_wdata and addr match, mem_rden=0;
  - d_ready pulses on mem_ready.
- D asserts rden and wren together: only mem_wren is driven.
- Reset asserted in BUSY with latency 10:
  - all strobes drop that cycle, no ready pulse;
  - the next request after reset is granted normally.
- With RISCV_ARB_TIMEOUT_EN, TIMEOUT_CYC=16, memory never responds:
  - ready pulses at cycle 16 of BUSY with rdata=0;
  - o_riscv_arb_timeout=1 and stays 1.

Source files
------------

// File: rtl/riscv_arb_pkg.sv
// rtl/riscv_arb_pkg.sv - shared encodings for the I/D memory arbiter
package riscv_arb_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    BUSY    = 2'b01,
    RELEASE = 2'b10
  } arb_state_e;

  // Requester identities, also used as bit positions in the req/grant vectors
  localparam logic REQ_D = 1'b0;
  localparam logic REQ_I = 1'b1;

  // Memory operation of the granted transaction
  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

endpackage

// File: rtl/riscv_mem_arbiter_if.sv
// rtl/riscv_mem_arbiter_if.sv - requester and memory bus bundle (optional RISCV_ARB_TIMEOUT_EN adds timeout flag)
interface riscv_mem_arbiter_if #(
  parameter int DATA_WIDTH = 128,
  parameter int S_ADDR     = 10
);
  logic                  i_riscv_arb_d_rden;
  logic                  i_riscv_arb_d_wren;
  logic [S_ADDR-1:0]     i_riscv_arb_d_addr;
  logic [DATA_WIDTH-1:0] i_riscv_arb_d_wdata;
  logic [DATA_WIDTH-1:0] o_riscv_arb_d_rdata;
  logic                  o_riscv_arb_d_ready;
  logic                  i_riscv_arb_i_rden;
  logic [S_ADDR-1:0]     i_riscv_arb_i_addr;
  logic [DATA_WIDTH-1:0] o_riscv_arb_i_rdata;
  logic                  o_riscv_arb_i_ready;
  logic                  o_riscv_arb_mem_rden;
  logic                  o_riscv_arb_mem_wren;
  logic [S_ADDR-1:0]     o_riscv_arb_mem_addr;
  logic [DATA_WIDTH-1:0] o_riscv_arb_mem_wdata;
  logic [DATA_WIDTH-1:0] i_riscv_arb_mem_rdata;
  logic                  i_riscv_arb_mem_ready;
`ifdef RISCV_ARB_TIMEOUT_EN
  logic                  o_riscv_arb_timeout;
`endif

  // Arbiter side
  modport slave (
    input  i_riscv_arb_d_rden, i_riscv_arb_d_wren, i_riscv_arb_d_addr, i_riscv_arb_d_wdata,
    input  i_riscv_arb_i_rden, i_riscv_arb_i_addr,
    input  i_riscv_arb_mem_rdata, i_riscv_arb_mem_ready,
    output o_riscv_arb_d_rdata, o_riscv_arb_d_ready, o_riscv_arb_i_rdata, o_riscv_arb_i_ready,
    output o_riscv_arb_mem_rden, o_riscv_arb_mem_wren, o_riscv_arb_mem_addr, o_riscv_arb_mem_wdata
`ifdef RISCV_ARB_TIMEOUT_EN
    , output o_riscv_arb_timeout
`endif
  );

  // Requester and memory side
  modport master (
    output i_riscv_arb_d_rden, i_riscv_arb_d_wren, i_riscv_arb_d_addr, i_riscv_arb_d_wdata,
    output i_riscv_arb_i_rden, i_riscv_arb_i_addr,
    output i_riscv_arb_mem_rdata, i_riscv_arb_mem_ready,
    input  o_riscv_arb_d_rdata, o_riscv_arb_d_ready, o_riscv_arb_i_rdata, o_riscv_arb_i_ready,
    input  o_riscv_arb_mem_rden, o_riscv_arb_mem_wren, o_riscv_arb_mem_addr, o_riscv_arb_mem_wdata
`ifdef RISCV_ARB_TIMEOUT_EN
    , input o_riscv_arb_timeout
`endif
  );

endinterface

// File: rtl/riscv_rr_arb2.sv
// rtl/riscv_rr_arb2.sv - two-input round-robin grant with priority pointer
module riscv_rr_arb2
  import riscv_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic rr_ptr;

  // Pointer breaks ties only; a lone requester always wins
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = (rr_ptr == REQ_I) ? 2'b10 : 2'b01;
    end
  end

  // After each grant the pointer favours the side that was not served
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= REQ_D;
    end else if (advance && (|grant)) begin
      rr_ptr <= grant[REQ_D] ? REQ_I : REQ_D;
    end
  end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// rtl/riscv_mem_arbiter.sv - I/D refill arbiter onto one memory (optional RISCV_ARB_TIMEOUT_EN watchdog)
module riscv_mem_arbiter
  import riscv_arb_pkg::*;
#(
  parameter int DATA_WIDTH  = 128,
  parameter int S_ADDR      = 10
`ifdef RISCV_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 1024
`endif
) (
  input logic                i_riscv_arb_clk,
  input logic                i_riscv_arb_rst,
  riscv_mem_arbiter_if.slave bus
);

  arb_state_e            state_q, state_d;
  logic                  gnt_q;
  logic                  op_q;
  logic [S_ADDR-1:0]     addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [1:0]            req;
  logic [1:0]            grant;
  logic                  gnt_id;
  logic                  start;
  logic                  tmo_hit;

  logic                  mem_rden, mem_wren, d_ready, i_ready;
  logic [S_ADDR-1:0]     mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata, d_rdata, i_rdata;

  assign req    = {bus.i_riscv_arb_i_rden, bus.i_riscv_arb_d_rden | bus.i_riscv_arb_d_wren};
  assign start  = (state_q == IDLE) && (|req);
  assign gnt_id = grant[REQ_I] ? REQ_I : REQ_D;

  riscv_rr_arb2 u_rr (
    .clk     (i_riscv_arb_clk),
    .rst     (i_riscv_arb_rst),
    .req     (req),
    .advance (start),
    .grant   (grant)
  );

`ifdef RISCV_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  logic [TW-1:0] tmo_cnt_q;
  logic          timeout_q;

  assign tmo_hit = (state_q == BUSY) && !bus.i_riscv_arb_mem_ready &&
                   (tmo_cnt_q == TW'(TIMEOUT_CYC - 1));

  // Count BUSY cycles; held at zero elsewhere so every BUSY starts fresh
  always_ff @(posedge i_riscv_arb_clk or posedge i_riscv_arb_rst) begin
    if (i_riscv_arb_rst) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q <= (state_q == BUSY) ? tmo_cnt_q + 1'b1 : '0;
      if (tmo_hit) timeout_q <= 1'b1;
    end
  end

  assign bus.o_riscv_arb_timeout = timeout_q;
`else
  assign tmo_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge i_riscv_arb_clk or posedge i_riscv_arb_rst) begin
    if (i_riscv_arb_rst) state_q <= IDLE;
    else                 state_q <= state_d;
  end

  // Capture the winner's transaction so later request changes are ignored
  always_ff @(posedge i_riscv_arb_clk or posedge i_riscv_arb_rst) begin
    if (i_riscv_arb_rst) begin
      gnt_q   <= REQ_D;
      op_q    <= OP_RD;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (start) begin
      gnt_q   <= gnt_id;
      op_q    <= (gnt_id == REQ_D && bus.i_riscv_arb_d_wren) ? OP_WR : OP_RD;
      addr_q  <= (gnt_id == REQ_I) ? bus.i_riscv_arb_i_addr : bus.i_riscv_arb_d_addr;
      wdata_q <= (gnt_id == REQ_D) ? bus.i_riscv_arb_d_wdata : '0;
    end
  end

  // Next state and outputs; strobes decode from state so reset drops them at once
  always_comb begin
    state_d   = state_q;
    mem_rden  = 1'b0;
    mem_wren  = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    d_ready   = 1'b0;
    i_ready   = 1'b0;
    d_rdata   = '0;
    i_rdata   = '0;
    case (state_q)
      IDLE: if (|req) state_d = BUSY;
      BUSY: begin
        mem_rden  = (op_q == OP_RD);
        mem_wren  = (op_q == OP_WR);
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (bus.i_riscv_arb_mem_ready) begin
          state_d = RELEASE;
          if (gnt_q == REQ_D) begin
            d_ready = 1'b1;
            d_rdata = bus.i_riscv_arb_mem_rdata;
          end else begin
            i_ready = 1'b1;
            i_rdata = bus.i_riscv_arb_mem_rdata;
          end
        end else if (tmo_hit) begin
          state_d = RELEASE;
          if (gnt_q == REQ_D) d_ready = 1'b1;
          else                i_ready = 1'b1;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.o_riscv_arb_mem_rden  = mem_rden;
  assign bus.o_riscv_arb_mem_wren  = mem_wren;
  assign bus.o_riscv_arb_mem_addr  = mem_addr;
  assign bus.o_riscv_arb_mem_wdata = mem_wdata;
  assign bus.o_riscv_arb_d_ready   = d_ready;
  assign bus.o_riscv_arb_d_rdata   = d_rdata;
  assign bus.o_riscv_arb_i_ready   = i_ready;
  assign bus.o_riscv_arb_i_rdata   = i_rdata;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb/tb_riscv_mem_arbiter.sv - self-checking bench for riscv_mem_arbiter (RISCV_ARB_TIMEOUT_EN section optional)
module tb_riscv_mem_arbiter;

  localparam int DW = 128;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  riscv_mem_arbiter_if #(.DATA_WIDTH(DW), .S_ADDR(AW)) bus ();

  riscv_mem_arbiter #(
    .DATA_WIDTH (DW),
    .S_ADDR     (AW)
`ifdef RISCV_ARB_TIMEOUT_EN
    , .TIMEOUT_CYC (16)
`endif
  ) dut (
    .i_riscv_arb_clk (clk),
    .i_riscv_arb_rst (rst),
    .bus             (bus)
  );

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] mem_arr [1024];
  logic [DW-1:0] ref_arr [1024];
  int            mem_lat = 1;
  int            mem_cnt = 0;
  bit            model_ptr = 1'b0;   // 0 = D favoured, 1 = I favoured

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory model: answers after mem_lat strobe cycles; mem_lat==0 never answers
  always @(negedge clk) begin
    if (!(bus.o_riscv_arb_mem_rden || bus.o_riscv_arb_mem_wren) || bus.i_riscv_arb_mem_ready) begin
      mem_cnt = 0;
      bus.i_riscv_arb_mem_ready = 1'b0;
      bus.i_riscv_arb_mem_rdata = '0;
    end else begin
      mem_cnt++;
      if (mem_lat != 0 && mem_cnt >= mem_lat) begin
        bus.i_riscv_arb_mem_ready = 1'b1;
        if (bus.o_riscv_arb_mem_wren) begin
          mem_arr[bus.o_riscv_arb_mem_addr] = bus.o_riscv_arb_mem_wdata;
          bus.i_riscv_arb_mem_rdata = '0;
        end else begin
          bus.i_riscv_arb_mem_rdata = mem_arr[bus.o_riscv_arb_mem_addr];
        end
      end
    end
  end

  // Sample point: 2 time units before the next rising edge
  task automatic tick();
    @(posedge clk);
    #8;
  endtask

  task automatic drop_all();
    bus.i_riscv_arb_d_rden = 1'b0;
    bus.i_riscv_arb_d_wren = 1'b0;
    bus.i_riscv_arb_i_rden = 1'b0;
  endtask

  // Reference arbitration: tie goes to pointer, lone requester wins, pointer moves to the loser
  function automatic bit pick(input bit d_req, input bit i_req);
    bit w;
    if (d_req && i_req) w = model_ptr;
    else                w = i_req;
    model_ptr = ~w;
    return w;
  endfunction

  // Issue one request set; each side drops its request after its ready
  task automatic run_pair(input string tag, input bit dr, input bit dw, input bit ir,
                          input logic [AW-1:0] da, input logic [AW-1:0] ia,
                          input logic [DW-1:0] wd, input int lat);
    bit d_pend, i_pend, first;
    bit order [$];
    int cyc;
    mem_lat = lat;
    d_pend = dr | dw;
    i_pend = ir;
    order.delete();
    first = pick(d_pend, i_pend);
    order.push_back(first);
    if (d_pend && i_pend) order.push_back(pick(first == 1'b1, first == 1'b0));
    bus.i_riscv_arb_d_rden  = dr;
    bus.i_riscv_arb_d_wren  = dw;
    bus.i_riscv_arb_d_addr  = da;
    bus.i_riscv_arb_d_wdata = wd;
    bus.i_riscv_arb_i_rden  = ir;
    bus.i_riscv_arb_i_addr  = ia;
    tick();
    chk({tag, "_grant_lat"}, bus.o_riscv_arb_mem_rden | bus.o_riscv_arb_mem_wren, 1'b1);
    chk({tag, "_first_addr"}, bus.o_riscv_arb_mem_addr, order[0] ? ia : da);
    cyc = 0;
    while ((d_pend || i_pend) && cyc < 200) begin
      if (bus.o_riscv_arb_d_ready) begin
        chk({tag, "_d_owner"}, order.size() != 0 && order[0] == 1'b0, 1'b1);
        chk({tag, "_d_addr"}, bus.o_riscv_arb_mem_addr, da);
        chk({tag, "_i_quiet"}, {bus.o_riscv_arb_i_ready, bus.o_riscv_arb_i_rdata}, '0);
        if (dw) begin
          chk({tag, "_wr_strobes"}, {bus.o_riscv_arb_mem_wren, bus.o_riscv_arb_mem_rden}, 2'b10);
          chk({tag, "_wr_data"}, bus.o_riscv_arb_mem_wdata, wd);
          ref_arr[da] = wd;
        end else begin
          chk({tag, "_d_rdata"}, bus.o_riscv_arb_d_rdata, ref_arr[da]);
        end
        if (order.size() != 0) void'(order.pop_front());
        d_pend = 1'b0;
        bus.i_riscv_arb_d_rden = 1'b0;
        bus.i_riscv_arb_d_wren = 1'b0;
      end else if (bus.o_riscv_arb_i_ready) begin
        chk({tag, "_i_owner"}, order.size() != 0 && order[0] == 1'b1, 1'b1);
        chk({tag, "_i_addr"}, bus.o_riscv_arb_mem_addr, ia);
        chk({tag, "_i_rdata"}, bus.o_riscv_arb_i_rdata, ref_arr[ia]);
        chk({tag, "_d_quiet"}, {bus.o_riscv_arb_d_ready, bus.o_riscv_arb_d_rdata}, '0);
        if (order.size() != 0) void'(order.pop_front());
        i_pend = 1'b0;
        bus.i_riscv_arb_i_rden = 1'b0;
      end
      if (d_pend || i_pend) tick();
      cyc++;
    end
    chk({tag, "_completed"}, {d_pend, i_pend}, 2'b00);
    drop_all();
    tick();
    chk({tag, "_release"}, {bus.o_riscv_arb_mem_rden, bus.o_riscv_arb_mem_wren}, 2'b00);
    tick();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ready_seen;
    bit owner;
    int early;
    for (int a = 0; a < 1024; a++) begin
      mem_arr[a] = {$urandom, $urandom, $urandom, $urandom};
      ref_arr[a] = mem_arr[a];
    end
    rst = 1'b1;
    drop_all();
    bus.i_riscv_arb_d_addr    = '0;
    bus.i_riscv_arb_d_wdata   = '0;
    bus.i_riscv_arb_i_addr    = '0;
    bus.i_riscv_arb_mem_ready = 1'b0;
    bus.i_riscv_arb_mem_rdata = '0;
    tick();
    tick();
    chk("reset_strobes", {bus.o_riscv_arb_mem_rden, bus.o_riscv_arb_mem_wren}, 2'b00);
    chk("reset_readies", {bus.o_riscv_arb_d_ready, bus.o_riscv_arb_i_ready}, 2'b00);
    chk("reset_addr", bus.o_riscv_arb_mem_addr, '0);
    chk("reset_wdata", bus.o_riscv_arb_mem_wdata, '0);
    chk("reset_rdata", bus.o_riscv_arb_d_rdata | bus.o_riscv_arb_i_rdata, '0);
`ifdef RISCV_ARB_TIMEOUT_EN
    chk("reset_timeout", bus.o_riscv_arb_timeout, 1'b0);
`endif
    rst = 1'b0;
    tick();

    // Both held for three transactions after reset: D, I, D
    mem_lat = 2;
    model_ptr = 1'b0;
    bus.i_riscv_arb_d_rden = 1'b1;
    bus.i_riscv_arb_d_addr = 10'h111;
    bus.i_riscv_arb_i_rden = 1'b1;
    bus.i_riscv_arb_i_addr = 10'h222;
    for (int n = 0; n < 3; n++) begin
      ready_seen = 1'b0;
      for (int c = 0; c < 20 && !ready_seen; c++) begin
        tick();
        if (bus.o_riscv_arb_d_ready || bus.o_riscv_arb_i_ready) begin
          ready_seen = 1'b1;
          owner = pick(1'b1, 1'b1);
          chk("alt_owner", {bus.o_riscv_arb_i_ready, bus.o_riscv_arb_d_ready}, owner ? 2'b10 : 2'b01);
          chk("alt_addr", bus.o_riscv_arb_mem_addr, owner ? 10'h222 : 10'h111);
        end
      end
      chk("alt_seen", ready_seen, 1'b1);
    end
    drop_all();
    tick();
    tick();

    // Directed cases
    run_pair("d_read", 1'b1, 1'b0, 1'b0, 10'h055, 10'h000, '0, 3);
    run_pair("d_write", 1'b0, 1'b1, 1'b0, 10'h3FF, 10'h000,
             128'h0123456789ABCDEF0123456789ABCDEF, 2);
    run_pair("d_rdwr", 1'b1, 1'b1, 1'b0, 10'h0A0, 10'h000, {4{$urandom}}, 1);
    run_pair("d_readback", 1'b1, 1'b0, 1'b1, 10'h3FF, 10'h055, '0, 2);

    // Reset in the middle of a long transaction
    mem_lat = 10;
    bus.i_riscv_arb_d_rden = 1'b1;
    bus.i_riscv_arb_d_addr = 10'h155;
    tick();
    tick();
    tick();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_mid_strobes", {bus.o_riscv_arb_mem_rden, bus.o_riscv_arb_mem_wren}, 2'b00);
    chk("rst_mid_ready", {bus.o_riscv_arb_d_ready, bus.o_riscv_arb_i_ready}, 2'b00);
    early = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (bus.o_riscv_arb_d_ready || bus.o_riscv_arb_i_ready) early++;
    end
    chk("rst_no_ready", early, 0);
    drop_all();
    rst = 1'b0;
    model_ptr = 1'b0;
    tick();
    run_pair("post_rst_both", 1'b1, 1'b0, 1'b1, 10'h155, 10'h2AA, '0, 2);

    // Randomized traffic
    for (int n = 0; n < 24; n++) begin
      int kind;
      bit ir;
      kind = $urandom_range(0, 3);
      ir   = $urandom_range(0, 1);
      if (kind == 0) ir = 1'b1;
      run_pair("rand", kind == 1 || kind == 3, kind >= 2, ir,
               AW'($urandom), AW'($urandom), {$urandom, $urandom, $urandom, $urandom},
               $urandom_range(1, 5));
    end

`ifdef RISCV_ARB_TIMEOUT_EN
    // Memory never answers: watchdog completes the read with zero data
    mem_lat = 0;
    bus.i_riscv_arb_i_rden = 1'b1;
    bus.i_riscv_arb_i_addr = 10'h077;
    early = 0;
    for (int c = 1; c < 16; c++) begin
      tick();
      if (bus.o_riscv_arb_i_ready || bus.o_riscv_arb_d_ready) early++;
    end
    chk("tmo_no_early", early, 0);
    tick();
    chk("tmo_ready", bus.o_riscv_arb_i_ready, 1'b1);
    chk("tmo_rdata", bus.o_riscv_arb_i_rdata, '0);
    chk("tmo_flag", bus.o_riscv_arb_timeout, 1'b1);
    drop_all();
    for (int c = 0; c < 5; c++) tick();
    chk("tmo_sticky", bus.o_riscv_arb_timeout, 1'b1);
    mem_lat = 2;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
